// File: rtl/generic_spi_peripheral.sv
`timescale 1ns/1ps
// generic_spi_peripheral
// SPI mode-0 peripheral that gives an external controller read/write access to
// a bank of DATA_WIDTH-bit registers. The same bank is visible to the fabric
// through a simple host port. All SPI inputs are oversampled in the axi_clk
// domain, and axi_clk must run at least 8x faster than spi_clk.
//
// Frame: command byte {rw, addr[6:0]} followed by DATA_WIDTH data bits, MSB
// first. Bits are sampled on spi_clk rising edges. Read data is shifted out on
// falling edges.
//
// Handshake: there is no valid/ready pair. host_we is a single-cycle write
// strobe that is qualified by host_addr. host_rdata returns reg[host_addr] one
// cycle later. wr_pulse is high for exactly one cycle per committed SPI write.
//
// Ports:
//   axi_clk, axi_resetn         clock, asynchronous active-low reset
//   spi_clk, cs_b, pico         SPI inputs (asynchronous)
//   poci, poci_en               SPI data out and its tristate enable
//   host_addr/we/wdata/rdata    fabric register port
//   wr_pulse, wr_addr           SPI write strobe and last written address
//   frame_count, frame_err      completed-frame counter, sticky abort flag
//   dbg_state                   current FSM state (IDLE=0 CMD=1 DATA=2 WAIT_CS=3)
module generic_spi_peripheral #(
  parameter int REG_DEPTH  = 64,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  axi_clk,
  input  logic                  axi_resetn,
  input  logic                  spi_clk,
  input  logic                  cs_b,
  input  logic                  pico,
  output logic                  poci,
  output logic                  poci_en,
  input  logic [6:0]            host_addr,
  input  logic                  host_we,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  wr_pulse,
  output logic [6:0]            wr_addr,
  output logic [31:0]           frame_count,
  output logic                  frame_err,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, DATA = 2'd2, WAIT_CS = 2'd3} state_t;

  localparam int AW = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;

  state_t                r_state, w_next;
  logic                  r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic                  r_cs_s1, r_cs_s2, r_cs_d;
  logic                  r_pico_s1, r_pico_s2;
  logic [1:0]            r_warm;
  logic                  r_armed;
  logic [5:0]            r_bit_cnt;
  logic [7:0]            r_cmd;
  logic [DATA_WIDTH-2:0] r_rx;
  logic [DATA_WIDTH-1:0] r_tx;
  logic                  r_poci;
  logic [DATA_WIDTH-1:0] r_regs [REG_DEPTH];

  logic                  w_sclk_rise, w_sclk_fall, w_cs_fall;
  logic                  w_cmd_done, w_data_done, w_abort;
  logic [7:0]            w_cmd_full;
  logic [DATA_WIDTH-1:0] w_rx_full;
  logic                  w_cmd_addr_ok, w_wr_addr_ok, w_host_ok, w_spi_wr;

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
  // Until the synchroniser has flushed its reset value and cs_b has been seen
  // high, a low cs_b (for example, one held through reset) does not start a frame.
  assign w_cs_fall   = r_armed & ~r_cs_s2 & r_cs_d;

  assign w_cmd_full    = {r_cmd[6:0], r_pico_s2};
  assign w_rx_full     = {r_rx, r_pico_s2};
  assign w_cmd_addr_ok = {1'b0, w_cmd_full[6:0]} < 8'(REG_DEPTH);
  assign w_wr_addr_ok  = {1'b0, r_cmd[6:0]} < 8'(REG_DEPTH);
  assign w_host_ok     = {1'b0, host_addr} < 8'(REG_DEPTH);
  assign w_spi_wr      = w_data_done & r_cmd[7] & w_wr_addr_ok;

  assign poci      = r_poci;
  assign poci_en   = ~r_cs_s2;
  assign dbg_state = r_state;

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_cmd_done  = 1'b0;
    w_data_done = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      IDLE: if (w_cs_fall) w_next = CMD;
      CMD: begin
        if (r_cs_s2) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end else if (w_sclk_rise && r_bit_cnt == 6'd7) begin
          w_next     = DATA;
          w_cmd_done = 1'b1;
        end
      end
      DATA: begin
        if (r_cs_s2) begin
          w_next  = IDLE;
          w_abort = 1'b1;
        end else if (w_sclk_rise && r_bit_cnt == 6'(DATA_WIDTH - 1)) begin
          w_next      = WAIT_CS;
          w_data_done = 1'b1;
        end
      end
      WAIT_CS: if (r_cs_s2) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_sclk_s1   <= 1'b0;
      r_sclk_s2   <= 1'b0;
      r_sclk_d    <= 1'b0;
      r_cs_s1     <= 1'b1;
      r_cs_s2     <= 1'b1;
      r_cs_d      <= 1'b1;
      r_pico_s1   <= 1'b0;
      r_pico_s2   <= 1'b0;
      r_warm      <= 2'b00;
      r_armed     <= 1'b0;
      r_bit_cnt   <= 6'd0;
      r_cmd       <= 8'd0;
      r_rx        <= '0;
      r_tx        <= '0;
      r_poci      <= 1'b0;
      host_rdata  <= '0;
      wr_pulse    <= 1'b0;
      wr_addr     <= 7'd0;
      frame_count <= 32'd0;
      frame_err   <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_clk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_cs_s1   <= cs_b;
      r_cs_s2   <= r_cs_s1;
      r_cs_d    <= r_cs_s2;
      r_pico_s1 <= pico;
      r_pico_s2 <= r_pico_s1;
      r_warm    <= {r_warm[0], 1'b1};
      if (r_warm[1] && r_cs_s2) r_armed <= 1'b1;

      // The bit counter restarts whenever the state changes.
      if (w_next != r_state)
        r_bit_cnt <= 6'd0;
      else if (w_sclk_rise && (r_state == CMD || r_state == DATA))
        r_bit_cnt <= r_bit_cnt + 6'd1;

      if (w_sclk_rise && r_state == CMD)  r_cmd <= w_cmd_full;
      if (w_sclk_rise && r_state == DATA) r_rx  <= w_rx_full[DATA_WIDTH-2:0];

      // Write frames load zeros, so poci stays low during their data phase.
      if (w_cmd_done)
        r_tx <= (!w_cmd_full[7] && w_cmd_addr_ok) ? r_regs[w_cmd_full[AW-1:0]] : '0;
      else if (r_state == DATA && w_sclk_fall)
        r_tx <= {r_tx[DATA_WIDTH-2:0], 1'b0};

      if (w_next != DATA)
        r_poci <= 1'b0;
      else if (r_state == DATA && w_sclk_fall)
        r_poci <= r_tx[DATA_WIDTH-1];

      host_rdata <= w_host_ok ? r_regs[host_addr[AW-1:0]] : '0;

      wr_pulse <= w_spi_wr;
      if (w_spi_wr) wr_addr <= r_cmd[6:0];
      if (w_data_done) frame_count <= frame_count + 32'd1;
      if (w_abort) frame_err <= 1'b1;
    end
  end

  // Register bank. The SPI write is assigned last so that it wins a
  // same-address collision with host_we.
  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
    end else begin
      if (host_we && w_host_ok) r_regs[host_addr[AW-1:0]] <= host_wdata;
      if (w_spi_wr)             r_regs[r_cmd[AW-1:0]]     <= w_rx_full;
    end
  end

endmodule

// File: tb/tb_generic_spi_peripheral.sv
`timescale 1ns/1ps
module tb_generic_spi_peripheral;
  localparam int W      = 16;
  localparam int T_HALF = 60;   // spi_clk half period (axi_clk period 10 ns)

  logic          axi_clk = 1'b0;
  logic          axi_resetn = 1'b0;
  logic          spi_clk = 1'b0;
  logic          cs_b = 1'b1;
  logic          pico = 1'b0;
  logic          poci, poci_en;
  logic [6:0]    host_addr = 7'd0;
  logic          host_we = 1'b0;
  logic [W-1:0]  host_wdata = '0;
  logic [W-1:0]  host_rdata;
  logic          wr_pulse;
  logic [6:0]    wr_addr;
  logic [31:0]   frame_count;
  logic          frame_err;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int pulse_cnt = 0;

  generic_spi_peripheral #(.REG_DEPTH(64), .DATA_WIDTH(W)) dut (
    .axi_clk(axi_clk), .axi_resetn(axi_resetn), .spi_clk(spi_clk), .cs_b(cs_b),
    .pico(pico), .poci(poci), .poci_en(poci_en), .host_addr(host_addr),
    .host_we(host_we), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr), .frame_count(frame_count),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 axi_clk = ~axi_clk;

  always @(negedge axi_clk) if (wr_pulse) pulse_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic host_write(input logic [6:0] a, input logic [W-1:0] d);
    @(negedge axi_clk);
    host_addr = a; host_wdata = d; host_we = 1'b1;
    @(negedge axi_clk);
    host_we = 1'b0;
  endtask

  task automatic host_read(input logic [6:0] a, output logic [W-1:0] d);
    @(negedge axi_clk);
    host_addr = a;
    @(negedge axi_clk);
    d = host_rdata;
  endtask

  // Clocks nbits of {cmd, data}, then ones beyond 24. Read data is sampled
  // just before each data rising edge, as a controller would do.
  task automatic spi_xfer(input logic [7:0] cmd, input logic [W-1:0] data,
                          input int nbits, input bit raise_cs,
                          output logic [W-1:0] rx, output int cmd_ones,
                          output logic en_seen);
    logic [23:0] frame;
    frame = {cmd, data};
    rx = '0; cmd_ones = 0; en_seen = 1'b0;
    cs_b = 1'b0;
    #(T_HALF);
    for (int i = 0; i < nbits; i++) begin
      pico = (i < 24) ? frame[23 - i] : 1'b1;
      #(T_HALF);
      if (i < 8) cmd_ones += int'(poci);
      else if (i < 24) rx = {rx[W-2:0], poci};
      if (i == 8) en_seen = poci_en;
      spi_clk = 1'b1;
      #(T_HALF);
      spi_clk = 1'b0;
    end
    if (raise_cs) begin
      #(T_HALF);
      cs_b = 1'b1;
      repeat (6) @(negedge axi_clk);
    end
  endtask

  logic [W-1:0] rx, rd, rd_at;
  int           ones, p0;
  logic         en, seen;

  initial begin
    repeat (3) @(negedge axi_clk);
    check("rst_poci", poci, 0);
    check("rst_poci_en", poci_en, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_wr_pulse", wr_pulse, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_state", dbg_state, 0);
    axi_resetn = 1'b1;
    repeat (4) @(negedge axi_clk);

    // SPI write 0x85 / 0xBEEF
    p0 = pulse_cnt;
    spi_xfer(8'h85, 16'hBEEF, 24, 1, rx, ones, en);
    check("wr5_pulses", pulse_cnt - p0, 1);
    check("wr5_wr_addr", wr_addr, 5);
    host_read(7'd5, rd);
    check("wr5_reg", rd, 16'hBEEF);
    check("wr5_frame_count", frame_count, 1);
    check("wr5_frame_err", frame_err, 0);

    // host write 9, SPI read back
    host_write(7'd9, 16'h1234);
    p0 = pulse_cnt;
    spi_xfer(8'h09, 16'h0000, 24, 1, rx, ones, en);
    check("rd9_poci_data", rx, 16'h1234);
    check("rd9_poci_cmd_zero", ones, 0);
    check("rd9_poci_en", en, 1);
    check("rd9_frame_count", frame_count, 2);
    check("rd9_no_pulse", pulse_cnt - p0, 0);
    check("idle_poci_en", poci_en, 0);

    // aborted write after 12 bits
    p0 = pulse_cnt;
    spi_xfer(8'h83, 16'hAAAA, 12, 1, rx, ones, en);
    host_read(7'd3, rd);
    check("abort_reg3", rd, 0);
    check("abort_frame_err", frame_err, 1);
    check("abort_frame_count", frame_count, 2);
    check("abort_no_pulse", pulse_cnt - p0, 0);
    check("abort_state", dbg_state, 0);

    // out-of-range write and read (addr 100)
    p0 = pulse_cnt;
    spi_xfer(8'hE4, 16'h5555, 24, 1, rx, ones, en);
    check("oor_wr_no_pulse", pulse_cnt - p0, 0);
    check("oor_wr_frame_count", frame_count, 3);
    check("oor_wr_addr_kept", wr_addr, 5);
    host_read(7'd36, rd);
    check("oor_no_alias_write", rd, 0);
    host_write(7'd36, 16'hFFFF);
    spi_xfer(8'h64, 16'h0000, 24, 1, rx, ones, en);
    check("oor_rd_poci", rx, 0);
    check("oor_rd_frame_count", frame_count, 4);
    host_read(7'd100, rd);
    check("oor_host_read", rd, 0);

    // extra bits after the frame are ignored
    p0 = pulse_cnt;
    spi_xfer(8'h8B, 16'h0F0F, 28, 1, rx, ones, en);
    host_read(7'd11, rd);
    check("extra_bits_reg", rd, 16'h0F0F);
    check("extra_bits_frame_count", frame_count, 5);
    check("extra_bits_pulses", pulse_cnt - p0, 1);

    // SPI write and host_we collide on addr 7
    host_write(7'd7, 16'h1111);
    seen = 1'b0; rd_at = '0;
    fork
      spi_xfer(8'h87, 16'h7777, 24, 1, rx, ones, en);
      begin
        @(negedge axi_clk);
        host_addr = 7'd7; host_wdata = 16'hDEAD; host_we = 1'b1;
        for (int k = 0; k < 3000; k++) begin
          @(negedge axi_clk);
          if (wr_pulse) begin
            seen = 1'b1;
            rd_at = host_rdata;
            break;
          end
        end
        host_we = 1'b0;
      end
    join
    check("collide_pulse_seen", seen, 1);
    check("collide_old_rdata", rd_at, 16'hDEAD);
    host_read(7'd7, rd);
    check("collide_spi_wins", rd, 16'h7777);
    check("collide_frame_count", frame_count, 6);

    // reset mid-frame, then a clean frame
    spi_xfer(8'h8A, 16'hC0DE, 10, 0, rx, ones, en);
    @(negedge axi_clk);
    axi_resetn = 1'b0; cs_b = 1'b1; spi_clk = 1'b0;
    repeat (4) @(negedge axi_clk);
    check("midrst_frame_count", frame_count, 0);
    check("midrst_frame_err", frame_err, 0);
    axi_resetn = 1'b1;
    repeat (6) @(negedge axi_clk);
    check("midrst_state_idle", dbg_state, 0);
    p0 = pulse_cnt;
    spi_xfer(8'h8A, 16'hC0DE, 24, 1, rx, ones, en);
    check("midrst_pulses", pulse_cnt - p0, 1);
    check("midrst_frame_count_after", frame_count, 1);
    check("midrst_frame_err_after", frame_err, 0);
    host_read(7'd10, rd);
    check("midrst_reg10", rd, 16'hC0DE);
    host_read(7'd5, rd);
    check("midrst_reg5_cleared", rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
